// File: rtl/ex_pkg.sv
// Shared constants and enums for the ex_pipe execute stage.
// EX_MUL_EN adds the MUL state used by the iterative multiplier.
package ex_pkg;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP        = 7'b0110011;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OP_32     = 7'b0111011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SRL  = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_OR,
        ALU_AND, ALU_SLL, ALU_SRL, ALU_SRA, ALU_MUL, ALU_ILL
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
`ifdef EX_MUL_EN
        ST_MUL   = 2'd2,
`endif
        ST_SHIFT = 2'd1
    } state_e;

    function automatic logic is_shift_op(input alu_op_e op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/ex_shifter.sv
// Iterative barrel shifter: moves at most SHIFT_STEP bit positions per cycle.
// done_o is combinational on the final step so the caller can capture result_o on that edge.
module ex_shifter
    import ex_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned SHIFT_STEP = 4
)(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_i,
    input  logic [XLEN-1:0]          data_i,
    input  logic [$clog2(XLEN)-1:0]  shamt_i,
    input  logic                     left_i,
    input  logic                     arith_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [XLEN-1:0]          result_o
);

    localparam int unsigned SHW = $clog2(XLEN);

    logic [XLEN-1:0] data_q, data_d;
    logic [SHW-1:0]  rem_q, rem_d, amt;
    logic            busy_q, busy_d;
    logic            left_q, arith_q;

    always_comb begin
        amt = rem_q;
        if (32'(rem_q) > SHIFT_STEP) amt = SHW'(SHIFT_STEP);
        if (left_q)       data_d = data_q << amt;
        else if (arith_q) data_d = $unsigned($signed(data_q) >>> amt);
        else              data_d = data_q >> amt;
        rem_d  = rem_q - amt;
        busy_d = busy_q && (rem_d != '0);
    end

    assign busy_o   = busy_q;
    assign done_o   = busy_q && (rem_d == '0);
    assign result_o = data_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            left_q  <= 1'b0;
            arith_q <= 1'b0;
        end else if (start_i) begin
            data_q  <= data_i;
            rem_q   <= shamt_i;
            busy_q  <= (shamt_i != '0);
            left_q  <= left_i;
            arith_q <= arith_i;
        end else if (busy_q) begin
            data_q  <= data_d;
            rem_q   <= rem_d;
            busy_q  <= busy_d;
        end
    end

endmodule

// File: rtl/ex_pipe.sv
// Registered RV32I/RV64I integer execute stage with valid/ready on both sides.
// Optional EX_MUL_EN adds a radix-2 shift-add MUL taking XLEN cycles.
//
// state    | meaning
// ST_IDLE  | ready for an instruction; single-cycle ops complete here
// ST_SHIFT | ex_shifter iterating; output register loads on its done
// ST_MUL   | shift-add multiply in progress (EX_MUL_EN only)
module ex_pipe
    import ex_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned SHIFT_STEP = 4
)(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [31:0]     inst_i,
    input  logic [4:0]      reg_waddr_i,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] reg_wdata_o,
    output logic [4:0]      reg_waddr_o,
    output logic            reg_we_o,
    output logic            illegal_o
);

    localparam int unsigned SHW = $clog2(XLEN);

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    logic [6:0]      opcode, f7;
    logic [2:0]      f3;
    logic            imm_sh_base, imm_sh_alt;
    alu_op_e         op;
    logic            word, ill, accept;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] alu_res, fast_res, sh_data, sh_result, sh_res_w;
    logic            sh_start, sh_busy, sh_done;
    logic            unused_inst;

    state_e          state_q;
    logic            out_valid_q, reg_we_q, illegal_q, word_q;
    logic [XLEN-1:0] reg_wdata_q;
    logic [4:0]      reg_waddr_q;

`ifdef EX_MUL_EN
    logic [XLEN-1:0] mcand_q, mplier_q, acc_q, mul_acc_d;
    logic [SHW:0]    mcnt_q;
    assign mul_acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif

    assign opcode      = inst_i[6:0];
    assign f3          = inst_i[14:12];
    assign f7          = inst_i[31:25];
    assign unused_inst = ^{inst_i[24:15], inst_i[11:7]};

    // RV64 immediate shifts use inst[25] as shamt[5], so only inst[31:26] qualifies them.
    assign imm_sh_base = (XLEN == 64) ? (inst_i[31:26] == 6'b000000) : (f7 == F7_BASE);
    assign imm_sh_alt  = (XLEN == 64) ? (inst_i[31:26] == 6'b010000) : (f7 == F7_ALT);

    always_comb begin
        op   = ALU_ILL;
        word = 1'b0;
        case (opcode)
            OP_IMM: begin
                case (f3)
                    F3_ADD:  op = ALU_ADD;
                    F3_SLT:  op = ALU_SLT;
                    F3_SLTU: op = ALU_SLTU;
                    F3_XOR:  op = ALU_XOR;
                    F3_OR:   op = ALU_OR;
                    F3_AND:  op = ALU_AND;
                    F3_SLL:  if (imm_sh_base) op = ALU_SLL;
                    F3_SRL:  begin
                        if (imm_sh_base)     op = ALU_SRL;
                        else if (imm_sh_alt) op = ALU_SRA;
                    end
                    default: op = ALU_ILL;
                endcase
            end
            OP: begin
                if (f7 == F7_BASE) begin
                    case (f3)
                        F3_ADD:  op = ALU_ADD;
                        F3_SLL:  op = ALU_SLL;
                        F3_SLT:  op = ALU_SLT;
                        F3_SLTU: op = ALU_SLTU;
                        F3_XOR:  op = ALU_XOR;
                        F3_SRL:  op = ALU_SRL;
                        F3_OR:   op = ALU_OR;
                        F3_AND:  op = ALU_AND;
                        default: op = ALU_ILL;
                    endcase
                end else if (f7 == F7_ALT) begin
                    if (f3 == F3_ADD)      op = ALU_SUB;
                    else if (f3 == F3_SRL) op = ALU_SRA;
                end else if (f7 == F7_MULDIV) begin
`ifdef EX_MUL_EN
                    if (f3 == F3_ADD) op = ALU_MUL;
`endif
                end
            end
            OP_IMM_32: begin
                if (XLEN == 64) begin
                    word = 1'b1;
                    if (f3 == F3_ADD)                         op = ALU_ADD;
                    else if (f3 == F3_SLL && f7 == F7_BASE)   op = ALU_SLL;
                    else if (f3 == F3_SRL && f7 == F7_BASE)   op = ALU_SRL;
                    else if (f3 == F3_SRL && f7 == F7_ALT)    op = ALU_SRA;
                end
            end
            OP_32: begin
                if (XLEN == 64) begin
                    word = 1'b1;
                    if (f7 == F7_BASE) begin
                        if (f3 == F3_ADD)      op = ALU_ADD;
                        else if (f3 == F3_SLL) op = ALU_SLL;
                        else if (f3 == F3_SRL) op = ALU_SRL;
                    end else if (f7 == F7_ALT) begin
                        if (f3 == F3_ADD)      op = ALU_SUB;
                        else if (f3 == F3_SRL) op = ALU_SRA;
                    end
                end
            end
            default: op = ALU_ILL;
        endcase
    end

    assign ill   = (op == ALU_ILL);
    assign shamt = word ? SHW'(op2_i[4:0]) : op2_i[SHW-1:0];

    // Shift ops reaching here have a zero shift amount and pass op1 through.
    always_comb begin
        case (op)
            ALU_ADD:  alu_res = op1_i + op2_i;
            ALU_SUB:  alu_res = op1_i - op2_i;
            ALU_SLT:  alu_res = XLEN'($signed(op1_i) < $signed(op2_i));
            ALU_SLTU: alu_res = XLEN'(op1_i < op2_i);
            ALU_XOR:  alu_res = op1_i ^ op2_i;
            ALU_OR:   alu_res = op1_i | op2_i;
            ALU_AND:  alu_res = op1_i & op2_i;
            ALU_SLL, ALU_SRL, ALU_SRA: alu_res = op1_i;
            default:  alu_res = '0;
        endcase
        fast_res = word ? sext32(alu_res[31:0]) : alu_res;
        sh_data  = op1_i;
        if (word) sh_data = (op == ALU_SRA) ? sext32(op1_i[31:0]) : XLEN'(op1_i[31:0]);
    end

    assign in_ready_o = (state_q == ST_IDLE) && !sh_busy && (!out_valid_q || out_ready_i);
    assign accept     = in_valid_i && in_ready_o;
    assign sh_start   = accept && !ill && is_shift_op(op) && (shamt != '0);
    assign sh_res_w   = word_q ? sext32(sh_result[31:0]) : sh_result;

    ex_shifter #(.XLEN(XLEN), .SHIFT_STEP(SHIFT_STEP)) u_shifter (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (sh_start),
        .data_i   (sh_data),
        .shamt_i  (shamt),
        .left_i   (op == ALU_SLL),
        .arith_i  (op == ALU_SRA),
        .busy_o   (sh_busy),
        .done_o   (sh_done),
        .result_o (sh_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            reg_we_q    <= 1'b0;
            illegal_q   <= 1'b0;
            word_q      <= 1'b0;
            reg_wdata_q <= '0;
            reg_waddr_q <= '0;
`ifdef EX_MUL_EN
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            mcnt_q      <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        reg_waddr_q <= reg_waddr_i;
                        word_q      <= word;
                        if (ill) begin
                            out_valid_q <= 1'b1;
                            reg_wdata_q <= '0;
                            reg_we_q    <= 1'b0;
                            illegal_q   <= 1'b1;
                        end else if (sh_start) begin
                            out_valid_q <= 1'b0;
                            reg_we_q    <= 1'b0;
                            illegal_q   <= 1'b0;
                            state_q     <= ST_SHIFT;
`ifdef EX_MUL_EN
                        end else if (op == ALU_MUL) begin
                            out_valid_q <= 1'b0;
                            reg_we_q    <= 1'b0;
                            illegal_q   <= 1'b0;
                            mcand_q     <= op1_i;
                            mplier_q    <= op2_i;
                            acc_q       <= '0;
                            mcnt_q      <= (SHW+1)'(XLEN);
                            state_q     <= ST_MUL;
`endif
                        end else begin
                            out_valid_q <= 1'b1;
                            reg_wdata_q <= fast_res;
                            reg_we_q    <= (reg_waddr_i != 5'd0);
                            illegal_q   <= 1'b0;
                        end
                    end else if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (sh_done) begin
                        out_valid_q <= 1'b1;
                        reg_wdata_q <= sh_res_w;
                        reg_we_q    <= (reg_waddr_q != 5'd0);
                        state_q     <= ST_IDLE;
                    end
                end
`ifdef EX_MUL_EN
                ST_MUL: begin
                    acc_q    <= mul_acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    mcnt_q   <= mcnt_q - 1'b1;
                    if (mcnt_q == (SHW+1)'(1)) begin
                        out_valid_q <= 1'b1;
                        reg_wdata_q <= mul_acc_d;
                        reg_we_q    <= (reg_waddr_q != 5'd0);
                        state_q     <= ST_IDLE;
                    end
                end
`endif
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign out_valid_o = out_valid_q;
    assign reg_wdata_o = reg_wdata_q;
    assign reg_waddr_o = reg_waddr_q;
    assign reg_we_o    = reg_we_q;
    assign illegal_o   = illegal_q;

endmodule

// File: tb/tb_ex_pipe.sv
// Directed bench for ex_pipe: expected results are queued when an instruction is
// driven and popped when the stage presents its output.
module tb_ex_pipe;

    localparam int XLEN = 32;
    localparam int SS   = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid_i = 1'b0;
    logic            out_ready_i = 1'b0;
    logic [31:0]     inst_i = '0;
    logic [4:0]      reg_waddr_i = '0;
    logic [XLEN-1:0] op1_i = '0;
    logic [XLEN-1:0] op2_i = '0;
    logic            in_ready_o, out_valid_o, reg_we_o, illegal_o;
    logic [XLEN-1:0] reg_wdata_o;
    logic [4:0]      reg_waddr_o;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic [XLEN-1:0] wdata;
        logic [4:0]      waddr;
        logic            we;
        logic            ill;
        int              lat;
    } exp_t;
    exp_t sb[$];

    ex_pipe #(.XLEN(XLEN), .SHIFT_STEP(SS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .inst_i      (inst_i),
        .reg_waddr_i (reg_waddr_i),
        .op1_i       (op1_i),
        .op2_i       (op2_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .reg_wdata_o (reg_wdata_o),
        .reg_waddr_o (reg_waddr_o),
        .reg_we_o    (reg_we_o),
        .illegal_o   (illegal_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [XLEN-1:0] w, input logic [4:0] a,
                        input logic we, input logic il, input int lat);
        exp_t e;
        e.wdata = w; e.waddr = a; e.we = we; e.ill = il; e.lat = lat;
        sb.push_back(e);
    endtask

    task automatic check_out(input string tag, output int lat);
        exp_t e;
        e.wdata = 'x; e.waddr = 'x; e.we = 1'bx; e.ill = 1'bx; e.lat = -1;
        if (sb.size() > 0) e = sb.pop_front();
        chk({tag, "_valid"}, 64'(out_valid_o), 64'(1));
        chk({tag, "_wdata"}, 64'(reg_wdata_o), 64'(e.wdata));
        chk({tag, "_waddr"}, 64'(reg_waddr_o), 64'(e.waddr));
        chk({tag, "_we"},    64'(reg_we_o),    64'(e.we));
        chk({tag, "_ill"},   64'(illegal_o),   64'(e.ill));
        lat = e.lat;
    endtask

    // Drives one instruction, waits for its result and checks value, latency and stall.
    task automatic run_op(input string tag, input logic [31:0] inst, input logic [4:0] rd,
                          input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        int k, stall, exp_lat;
        inst_i = inst; reg_waddr_i = rd; op1_i = a; op2_i = b;
        in_valid_i = 1'b1; out_ready_i = 1'b1;
        #1;
        k = 0;
        while (!in_ready_o && k < 100) begin step(); k++; end
        chk({tag, "_accept"}, 64'(in_ready_o), 64'(1));
        step();
        in_valid_i = 1'b0;
        k = 0; stall = 0;
        while (!out_valid_o && k < 200) begin
            if (!in_ready_o) stall++;
            step();
            k++;
        end
        check_out(tag, exp_lat);
        chk({tag, "_latency"}, 64'(k + 1), 64'(exp_lat));
        chk({tag, "_stall"}, 64'(stall), 64'(exp_lat - 1));
        chk({tag, "_ready_back"}, 64'(in_ready_o), 64'(1));
    endtask

    initial begin
        int dummy, seen;

        #12;
        chk("rst_valid", 64'(out_valid_o), 64'(0));
        chk("rst_we",    64'(reg_we_o),    64'(0));
        chk("rst_ill",   64'(illegal_o),   64'(0));
        chk("rst_wdata", 64'(reg_wdata_o), 64'(0));
        chk("rst_waddr", 64'(reg_waddr_o), 64'(0));
        chk("rst_ready", 64'(in_ready_o),  64'(1));
        rst_n = 1'b1;
        step();

        push(32'h0000_00ab, 5'd3, 1'b1, 1'b0, 1);
        run_op("addi", 32'hfff08013, 5'd3, 32'h42, 32'h69);

        push(32'h0000_2100, 5'd4, 1'b1, 1'b0, 1 + (7 + SS - 1) / SS);
        run_op("slli7", 32'h00769613, 5'd4, 32'h42, 32'd7);

        push(32'hf800_0000, 5'd5, 1'b1, 1'b0, 1 + (4 + SS - 1) / SS);
        run_op("srai4", 32'h4018d813, 5'd5, 32'h8000_0000, 32'd4);

        push(32'h0800_0000, 5'd5, 1'b1, 1'b0, 1 + (4 + SS - 1) / SS);
        run_op("srli4", 32'h0018d813, 5'd5, 32'h8000_0000, 32'd4);

        push(32'h8000_0000, 5'd6, 1'b1, 1'b0, 1 + (31 + SS - 1) / SS);
        run_op("slli31", 32'h00769613, 5'd6, 32'h3, 32'd31);

        push(32'h1234_5678, 5'd6, 1'b1, 1'b0, 1);
        run_op("slli0", 32'h00769613, 5'd6, 32'h1234_5678, 32'h20);

        push(32'hff00_0000, 5'd7, 1'b1, 1'b0, 1 + (4 + SS - 1) / SS);
        run_op("sra_reg", 32'h40005033, 5'd7, 32'hf000_0000, 32'h24);

        push(32'hffff_fffe, 5'd8, 1'b1, 1'b0, 1);
        run_op("sub", 32'h40000033, 5'd8, 32'd5, 32'd7);

        push(32'd12, 5'd8, 1'b1, 1'b0, 1);
        run_op("addi_b30", 32'h40000013, 5'd8, 32'd5, 32'd7);

        push(32'd1, 5'd9, 1'b1, 1'b0, 1);
        run_op("slt", 32'h00002033, 5'd9, 32'hffff_ffff, 32'd1);

        push(32'd0, 5'd9, 1'b1, 1'b0, 1);
        run_op("sltu", 32'h00003033, 5'd9, 32'hffff_ffff, 32'd1);

        push(32'hf0, 5'd0, 1'b0, 1'b0, 1);
        run_op("xor_x0", 32'h00004033, 5'd0, 32'hff, 32'h0f);

        push(32'hff, 5'd10, 1'b1, 1'b0, 1);
        run_op("or", 32'h00006033, 5'd10, 32'hf0, 32'h0f);

        push(32'h3c, 5'd11, 1'b1, 1'b0, 1);
        run_op("and", 32'h00007033, 5'd11, 32'hff, 32'h3c);

        push(32'h0, 5'd12, 1'b0, 1'b1, 1);
        run_op("illegal", 32'h0000007f, 5'd12, 32'h55, 32'h66);

        push(32'h0, 5'd12, 1'b0, 1'b1, 1);
        run_op("addiw_rv32", 32'h0000001b, 5'd12, 32'h55, 32'h66);

        push(32'h0, 5'd12, 1'b0, 1'b1, 1);
        run_op("op_alt_xor", 32'h40004033, 5'd12, 32'h55, 32'h66);

        // Backpressure: result held while the next instruction waits.
        in_valid_i = 1'b0; out_ready_i = 1'b1;
        step();
        chk("bp_drained", 64'(out_valid_o), 64'(0));
        inst_i = 32'hfff08013; reg_waddr_i = 5'd13; op1_i = 32'd1; op2_i = 32'd2;
        in_valid_i = 1'b1; out_ready_i = 1'b0;
        push(32'd3, 5'd13, 1'b1, 1'b0, 1);
        step();
        inst_i = 32'h00004033; reg_waddr_i = 5'd14; op1_i = 32'hff; op2_i = 32'h0f;
        push(32'hf0, 5'd14, 1'b1, 1'b0, 1);
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_ready_low", 64'(in_ready_o),  64'(0));
            chk("bp_hold_valid", 64'(out_valid_o), 64'(1));
            chk("bp_hold_wdata", 64'(reg_wdata_o), 64'(32'd3));
            chk("bp_hold_waddr", 64'(reg_waddr_o), 64'(5'd13));
            step();
        end
        check_out("bp_first", dummy);
        out_ready_i = 1'b1;
        #1;
        chk("bp_ready_release", 64'(in_ready_o), 64'(1));
        step();
        in_valid_i = 1'b0;
        check_out("bp_second", dummy);

        // Reset in the middle of a long shift.
        step();
        inst_i = 32'h00769613; reg_waddr_i = 5'd15; op1_i = 32'h1; op2_i = 32'd31;
        in_valid_i = 1'b1;
        step();
        in_valid_i = 1'b0;
        step();
        step();
        chk("mid_shift_valid", 64'(out_valid_o), 64'(0));
        chk("mid_shift_ready", 64'(in_ready_o),  64'(0));
        #3 rst_n = 1'b0;
        #1;
        chk("abort_valid", 64'(out_valid_o), 64'(0));
        chk("abort_idle",  64'(in_ready_o),  64'(1));
        step();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid_o) seen++;
            step();
        end
        chk("abort_no_result", 64'(seen), 64'(0));
        chk("abort_ready", 64'(in_ready_o), 64'(1));

`ifdef EX_MUL_EN
        push(32'h0001_2340, 5'd16, 1'b1, 1'b0, XLEN + 1);
`else
        push(32'h0, 5'd16, 1'b0, 1'b1, 1);
`endif
        run_op("mul", 32'h02000033, 5'd16, 32'h1234, 32'h10);

        push(32'd9, 5'd17, 1'b1, 1'b0, 1);
        run_op("add_after_mul", 32'h00000033, 5'd17, 32'd4, 32'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
